// File: rtl/seg_decode.sv
// Two-digit seven-segment reader: debounces a sign/digit pair and reports
// each newly stable pattern once as a 4-bit two's-complement value.
module seg_decode #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg0_in,
    input  logic [6:0] seg1_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_val,
    output logic       out_err,
    output logic [7:0] err_cnt,
    output logic [1:0] o_dbg_state
);

    // Handshake: a result transfers on a rising edge with out_valid and
    // out_ready both high; until then out_valid stays high and out_val/out_err
    // are frozen. out_ready is ignored while out_valid is low.

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [3:0]  STAB_MAX = 4'(STABLE_CYCLES);
    localparam logic [13:0] BLANK    = 14'h3FFF;

    state_t      r_state;
    logic [13:0] r_sync1;
    logic [13:0] r_sync2;
    logic [13:0] r_last;
    logic [3:0]  r_stab_cnt;
    logic        r_valid;
    logic [3:0]  r_val;
    logic        r_err;
    logic [7:0]  r_err_cnt;

    logic [2:0]  w_digit;
    logic        w_digit_ok;
    logic        w_pos;
    logic        w_neg;
    logic        w_dec_err;
    logic [3:0]  w_dec_val;
    logic        w_stable;
    logic        w_capture;

    always_comb begin
        w_digit    = 3'd0;
        w_digit_ok = 1'b1;
        case (r_sync2[6:0])
            7'b0000001: w_digit = 3'd0;
            7'b1001111: w_digit = 3'd1;
            7'b0010010: w_digit = 3'd2;
            7'b0000110: w_digit = 3'd3;
            7'b1001100: w_digit = 3'd4;
            7'b0100100: w_digit = 3'd5;
            7'b0100000: w_digit = 3'd6;
            7'b0001111: w_digit = 3'd7;
            default:    w_digit_ok = 1'b0;
        endcase
        w_pos     = (r_sync2[13:7] == 7'b1111111);
        w_neg     = (r_sync2[13:7] == 7'b1111110);
        w_dec_err = !w_digit_ok || !(w_pos || w_neg);
        if (w_dec_err) begin
            w_dec_val = 4'd0;
        end else if (w_pos) begin
            w_dec_val = {1'b0, w_digit};
        end else if (w_digit == 3'd0) begin
            w_dec_val = 4'b1000;
        end else begin
            w_dec_val = 4'd0 - {1'b0, w_digit};
        end
    end

    always_comb begin
        w_stable  = (r_stab_cnt == STAB_MAX);
        w_capture = w_stable &&
                    ((r_state == ST_INIT) ||
                     ((r_state == ST_WAIT) && (r_sync2 != r_last)));
    end

    // The counter looks at the value about to enter sync2, so it reads 1 in
    // the cycle sync2 first shows a new pair and saturation lines up with
    // STABLE_CYCLES cycles of sync2 holding that pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_sync1    <= BLANK;
            r_sync2    <= BLANK;
            r_last     <= BLANK;
            r_stab_cnt <= 4'd0;
            r_valid    <= 1'b0;
            r_val      <= 4'd0;
            r_err      <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_sync1 <= {seg1_in, seg0_in};
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2) begin
                r_stab_cnt <= 4'd1;
            end else if (r_stab_cnt != STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + 4'd1;
            end

            if (w_capture) begin
                r_state <= ST_HOLD;
                r_valid <= 1'b1;
                r_val   <= w_dec_val;
                r_err   <= w_dec_err;
                r_last  <= r_sync2;
                if (w_dec_err && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if ((r_state == ST_HOLD) && out_ready) begin
                r_state <= ST_WAIT;
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_val     = r_val;
    assign out_err     = r_err;
    assign err_cnt     = r_err_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg_decode.sv
// Bench for seg_decode: vector table, hand-built corner sequences and random
// stimulus, all scored against a window-based reference model.
module tb_seg_decode;

    localparam int          S     = 4;
    localparam logic [13:0] BLANK = 14'h3FFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg0_in;
    logic [6:0] seg1_in;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_val;
    logic       out_err;
    logic [7:0] err_cnt;
    logic [1:0] o_dbg_state;

    seg_decode #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg0_in    (seg0_in),
        .seg1_in    (seg1_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_val    (out_val),
        .out_err    (out_err),
        .err_cnt    (err_cnt),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] exp_q[$];   // {err, val} of the result the model says is on offer

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] digit_pat [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};

    function automatic logic [4:0] ref_decode(input logic [13:0] pair);
        int d = -1;
        for (int i = 0; i < 8; i++) begin
            if (pair[6:0] == digit_pat[i]) d = i;
        end
        if (d < 0 || (pair[13:7] != 7'h7F && pair[13:7] != 7'h7E)) return {1'b1, 4'd0};
        if (pair[13:7] == 7'h7F) return {1'b0, 4'(d)};
        if (d == 0) return {1'b0, 4'd8};
        return {1'b0, 4'((16 - d) % 16)};
    endfunction

    logic [13:0] m_seen;          // pair the DUT sampled at the previous edge
    logic [13:0] m_s2_hist[$];    // pair visible to the decoder after each edge since reset
    bit          m_reported;
    bit          m_holding;
    logic [13:0] m_last;
    int          m_cnt;

    function automatic logic [13:0] m_s2_now();
        if (m_s2_hist.size() == 0) return BLANK;
        return m_s2_hist[m_s2_hist.size() - 1];
    endfunction

    function automatic bit m_stable();
        int n = m_s2_hist.size();
        if (n < S) return 1'b0;
        for (int i = 1; i < S; i++) begin
            if (m_s2_hist[n - 1 - i] != m_s2_hist[n - 1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_seen     = BLANK;
        m_s2_hist.delete();
        m_reported = 1'b0;
        m_holding  = 1'b0;
        m_last     = BLANK;
        m_cnt      = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic [13:0] s2 = m_s2_now();
        logic [4:0]  r;
        if (m_holding) begin
            if (out_ready) begin
                m_holding = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (m_stable() && (!m_reported || s2 != m_last)) begin
            r = ref_decode(s2);
            exp_q.push_back(r);
            m_last     = s2;
            m_holding  = 1'b1;
            m_reported = 1'b1;
            if (r[4] && m_cnt < 255) m_cnt++;
        end
        m_s2_hist.push_back(m_seen);
        if (m_s2_hist.size() > 32) void'(m_s2_hist.pop_front());
        m_seen = {seg1_in, seg0_in};
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_holding));
        if (m_holding && exp_q.size() > 0) check("result", 32'({out_err, out_val}), 32'(exp_q[0]));
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_pair(input logic [6:0] s1, input logic [6:0] s0);
        seg1_in = s1;
        seg0_in = s0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok && out_valid) ok = 1'b1;
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL wait_valid: out_valid=0 after %0d cycles, expected 1", budget);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0] s1;
        logic [6:0] s0;
        logic [3:0] val;
        logic       err;
    } vec_t;

    vec_t vecs[19];

    task automatic fill_vecs();
        vecs[0]  = '{7'h7F, 7'b0000001, 4'h0, 1'b0};
        vecs[1]  = '{7'h7F, 7'b1001111, 4'h1, 1'b0};
        vecs[2]  = '{7'h7F, 7'b0010010, 4'h2, 1'b0};
        vecs[3]  = '{7'h7F, 7'b0000110, 4'h3, 1'b0};
        vecs[4]  = '{7'h7F, 7'b1001100, 4'h4, 1'b0};
        vecs[5]  = '{7'h7F, 7'b0100100, 4'h5, 1'b0};
        vecs[6]  = '{7'h7F, 7'b0100000, 4'h6, 1'b0};
        vecs[7]  = '{7'h7F, 7'b0001111, 4'h7, 1'b0};
        vecs[8]  = '{7'h7E, 7'b0000001, 4'h8, 1'b0};
        vecs[9]  = '{7'h7E, 7'b1001111, 4'hF, 1'b0};
        vecs[10] = '{7'h7E, 7'b0010010, 4'hE, 1'b0};
        vecs[11] = '{7'h7E, 7'b0000110, 4'hD, 1'b0};
        vecs[12] = '{7'h7E, 7'b1001100, 4'hC, 1'b0};
        vecs[13] = '{7'h7E, 7'b0100100, 4'hB, 1'b0};
        vecs[14] = '{7'h7E, 7'b0100000, 4'hA, 1'b0};
        vecs[15] = '{7'h7E, 7'b0001111, 4'h9, 1'b0};
        vecs[16] = '{7'h7F, 7'b1111110, 4'h0, 1'b1};
        vecs[17] = '{7'h00, 7'b0000110, 4'h0, 1'b1};
        vecs[18] = '{7'h7E, 7'b1111111, 4'h0, 1'b1};
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit       saw_valid;
        int       pick;
        logic [6:0] rs0;
        logic [6:0] rs1;

        fill_vecs();
        out_ready = 1'b0;
        set_pair(7'h7F, 7'h7F);
        model_reset();
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_val", 32'(out_val), 32'd0);
        check("reset_err", 32'(out_err), 32'd0);
        check("reset_cnt", 32'(err_cnt), 32'd0);
        check("reset_state", 32'(o_dbg_state), 32'd0);

        // Latency: pair in place before the first edge after release.
        set_pair(7'h7F, 7'b0000110);
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(5);
        check("lat_early", 32'(out_valid), 32'd0);
        tick();
        check("lat_on_time", 32'(out_valid), 32'd1);
        check("lat_val", 32'(out_val), 32'h3);
        check("lat_err", 32'(out_err), 32'd0);
        accept();
        check("lat_drop", 32'(out_valid), 32'd0);

        // Blank digit is illegal; holding it after accept gives no re-report.
        set_pair(7'h7F, 7'h7F);
        wait_valid(20);
        check("ill_err", 32'(out_err), 32'd1);
        check("ill_val", 32'(out_val), 32'd0);
        check("ill_cnt", 32'(err_cnt), 32'd1);
        accept();
        saw_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            saw_valid |= out_valid;
        end
        check("ill_no_rereport", 32'(saw_valid), 32'd0);

        // Table of every legal pattern plus illegal ones.
        for (int i = 0; i < 19; i++) begin
            set_pair(vecs[i].s1, vecs[i].s0);
            wait_valid(20);
            check($sformatf("vec%0d_val", i), 32'(out_val), 32'(vecs[i].val));
            check($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].err));
            accept();
        end

        // Toggle faster than the stability window, then settle.
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_pair(7'h7F, (i % 2 == 0) ? 7'b0000110 : 7'b1001100);
            for (int k = 0; k < 3; k++) begin
                tick();
                saw_valid |= out_valid;
            end
        end
        check("toggle_no_valid", 32'(saw_valid), 32'd0);
        wait_valid(20);
        check("toggle_settle_val", 32'(out_val), 32'h4);
        accept();
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_valid |= out_valid;
        end
        check("toggle_single_report", 32'(saw_valid), 32'd0);

        // Back-pressure: input moves 2 -> 5 while the 2 is still on offer.
        set_pair(7'h7F, 7'b0010010);
        wait_valid(20);
        check("bp_first", 32'(out_val), 32'h2);
        set_pair(7'h7F, 7'b0100100);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_val", 32'(out_val), 32'h2);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        accept();
        check("bp_idle_gap", 32'(out_valid), 32'd0);
        tick();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_val", 32'(out_val), 32'h5);
        accept();

        // Random pairs, hold times and back-pressure.
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 22);
            if (pick < 19) begin
                rs1 = vecs[pick].s1;
                rs0 = vecs[pick].s0;
            end else begin
                rs1 = 7'($urandom_range(0, 127));
                rs0 = 7'($urandom_range(0, 127));
            end
            set_pair(rs1, rs0);
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        // Drain anything pending before the saturation run.
        set_pair(7'h7F, 7'b0100000);
        out_ready = 1'b1;
        tick_n(20);
        out_ready = 1'b0;

        // Alternate two illegal pairs until err_cnt saturates.
        for (int k = 0; k < 300; k++) begin
            set_pair(7'h7F, (k % 2 == 0) ? 7'h7F : 7'b1111110);
            wait_valid(20);
            accept();
        end
        check("cnt_saturated", 32'(err_cnt), 32'd255);

        // Asynchronous reset while a result is on offer.
        set_pair(7'h7E, 7'b0100000);
        wait_valid(20);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        set_pair(7'h7F, 7'h7F);
        #1;
        model_reset();
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_cnt", 32'(err_cnt), 32'd0);
        check("async_state", 32'(o_dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First stable pair after reset is reported even when all blank.
        wait_valid(20);
        check("blank_err", 32'(out_err), 32'd1);
        check("blank_val", 32'(out_val), 32'd0);
        check("blank_cnt", 32'(err_cnt), 32'd1);
        accept();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_decode.md
SEG_DECODE -- requirements
Module: seg_decode

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..15: consecutive identical samples required before a pattern is accepted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port seg0_in  input  7  digit segments, active-low, bit6=a .. bit0=g.
REQ-005 SHALL have port seg1_in  input  7  sign segments, active-low, same bit order.
REQ-006 SHALL have port out_valid  output  1  decoded result available.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-008 SHALL have port out_val  output  4  decoded two's-complement value.
REQ-009 SHALL have port out_err  output  1  result came from an illegal pattern.
REQ-010 SHALL have port err_cnt  output  8  count of illegal results reported, saturating.

Function
REQ-011 SHALL pass seg0_in and seg1_in together through two register stages (sync1, sync2) before any use.
REQ-012 SHALL keep stab_cnt: set to 1 when sync2 differs from its previous-cycle value, else increment, saturating at STABLE_CYCLES.
REQ-013 SHALL treat the sync2 pair as stable while stab_cnt == STABLE_CYCLES.
REQ-014 SHALL decode seg0 digits: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7; any other seg0 is illegal.
REQ-015 SHALL decode seg1: 1111111=positive, 1111110=negative; any other seg1 is illegal.
REQ-016 SHALL output out_val = {0,d} for positive digit d, and 16-d (mod 16) for negative digit d in 1..7.
REQ-017 SHALL decode negative with digit 0 ("-0") as out_val=4'b1000 (-8).
REQ-018 SHALL, for an illegal pair, report out_err=1 and out_val=4'b0000.
REQ-019 SHALL implement FSM states INIT (no report since reset), WAIT, HOLD.
REQ-020 INIT: pair stable -> capture decode, HOLD.
REQ-021 WAIT: pair stable and raw 14-bit pair != last reported pair -> capture decode, HOLD; otherwise stay.
REQ-022 HOLD: out_valid=1; out_val/out_err SHALL not change; out_ready=1 -> WAIT, out_valid=0 next cycle.
REQ-023 SHALL store the raw pair as last reported pair on every capture.
REQ-024 SHALL keep stab_cnt and sync stages running in all states; a pair that changes and re-stabilises during HOLD is evaluated in WAIT against the last reported pair.
REQ-025 SHALL allow at most one capture per HOLD exit, giving at least one idle cycle between consecutive out_valid pulses.
REQ-026 SHALL increment err_cnt on each capture with out_err=1, holding at 255.
REQ-027 SHALL, from an input change applied before rising edge 0 and held, assert out_valid after rising edge STABLE_CYCLES+1 (6 edges with default).
REQ-028 SHALL treat out_ready outside HOLD as don't-care.

Reset
REQ-029 SHALL on rst_n=0, asynchronously: state=INIT, out_valid=0, out_val=0, out_err=0, err_cnt=0, stab_cnt=0, sync1/sync2/previous/last reported = 14'h3FFF.
REQ-030 SHALL, on reset asserted during HOLD, drop out_valid immediately and discard the pending result.
REQ-031 SHALL, after rst_n release, report the first stable pair even if it equals 14'h3FFF (all blank, illegal).

Verification
REQ-032 Reset released, seg1=1111111, seg0=0000110 held -> out_valid high after edge 5, out_val=0011, out_err=0; out_ready=1 -> out_valid low next cycle.
REQ-033 seg1=1111110, seg0=0000001 -> out_val=1000; seg0=1001111 -> out_val=1111; seg0=0001111 -> out_val=1001.
REQ-034 seg0 toggled every 3 cycles with STABLE_CYCLES=4 -> out_valid never asserts; then held -> one report.
REQ-035 seg0=1111111 held -> out_err=1, out_val=0000, err_cnt 0->1; same pair held after accept -> no further report; 300 alternating illegal reports -> err_cnt=255.
REQ-036 out_ready=0 in HOLD while input changes 2->5 -> out_val stays 2; on accept -> WAIT, then 5 reported next possible cycle.
REQ-037 rst_n pulsed low mid-HOLD -> out_valid=0 asynchronously, err_cnt=0, state INIT.
